// File: rtl/ex_mem_pipe_reg.sv
// EX->MEM pipeline register with stall/flush, access alignment checking and fault capture.
// Optional EM_PERF_CNT_EN adds load/store/fault/bubble event counters.
module ex_mem_pipe_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             StallM,
  input  logic             FlushM,
  input  logic             ValidE,
  input  logic             RegWriteE,
  input  logic             MemWriteE,
  input  logic             ResultSrcE,
  input  logic             LoadSignE,
  input  logic [1:0]       LoadSrcE,
  input  logic [4:0]       RdE,
  input  logic [WIDTH-1:0] ALUResultE,
  input  logic [WIDTH-1:0] WriteDataE,
  input  logic [WIDTH-1:0] PCPlus4E,
  output logic             ValidM,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic             ResultSrcM,
  output logic             LoadSignM,
  output logic [1:0]       LoadSrcM,
  output logic [4:0]       RdM,
  output logic [WIDTH-1:0] ALUResultM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [WIDTH-1:0] PCPlus4M,
  output logic             MisalignM,
  output logic [WIDTH-1:0] FaultAddrM
`ifdef EM_PERF_CNT_EN
  ,
  output logic [31:0]      LoadCntM,
  output logic [31:0]      StoreCntM,
  output logic [31:0]      FaultCntM,
  output logic [31:0]      BubbleCntM
`endif
);

  logic access;
  logic fault;

  always_comb begin
    access = ValidE & (MemWriteE | ResultSrcE);
    fault  = 1'b0;
    unique case (LoadSrcE)
      2'b00:   fault = access & (ALUResultE[1:0] != 2'b00);
      2'b01:   fault = access & ALUResultE[0];
      2'b10:   fault = 1'b0;
      default: fault = access;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      LoadSignM  <= 1'b0;
      LoadSrcM   <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      MisalignM  <= 1'b0;
      FaultAddrM <= '0;
    end else if (FlushM) begin
      // Bubble clears the whole slot; FaultAddrM keeps the last fault.
      ValidM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      LoadSignM  <= 1'b0;
      LoadSrcM   <= '0;
      RdM        <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      MisalignM  <= 1'b0;
    end else if (!StallM) begin
      ValidM     <= ValidE;
      RegWriteM  <= ValidE & RegWriteE & ~fault;
      MemWriteM  <= ValidE & MemWriteE & ~fault;
      ResultSrcM <= ValidE & ResultSrcE & ~fault;
      LoadSignM  <= LoadSignE;
      LoadSrcM   <= LoadSrcE;
      RdM        <= RdE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      PCPlus4M   <= PCPlus4E;
      MisalignM  <= fault;
      if (fault) begin
        FaultAddrM <= ALUResultE;
      end
    end
  end

`ifdef EM_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LoadCntM   <= '0;
      StoreCntM  <= '0;
      FaultCntM  <= '0;
      BubbleCntM <= '0;
    end else if (FlushM || (!StallM && !ValidE)) begin
      BubbleCntM <= BubbleCntM + 32'd1;
    end else if (!StallM) begin
      if (fault) begin
        FaultCntM <= FaultCntM + 32'd1;
      end else begin
        if (ResultSrcE) LoadCntM  <= LoadCntM + 32'd1;
        if (MemWriteE)  StoreCntM <= StoreCntM + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: directed cases then random traffic against a slot-level model.
module tb_ex_mem_pipe_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallM = 1'b0, FlushM = 1'b0, ValidE = 1'b0, RegWriteE = 1'b0;
  logic        MemWriteE = 1'b0, ResultSrcE = 1'b0, LoadSignE = 1'b0;
  logic [1:0]  LoadSrcE = '0;
  logic [4:0]  RdE = '0;
  logic [31:0] ALUResultE = '0, WriteDataE = '0, PCPlus4E = '0;
  logic        ValidM, RegWriteM, MemWriteM, ResultSrcM, LoadSignM, MisalignM;
  logic [1:0]  LoadSrcM;
  logic [4:0]  RdM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M, FaultAddrM;
`ifdef EM_PERF_CNT_EN
  logic [31:0] LoadCntM, StoreCntM, FaultCntM, BubbleCntM;
`endif

  ex_mem_pipe_reg #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .StallM(StallM), .FlushM(FlushM), .ValidE(ValidE),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
    .LoadSignE(LoadSignE), .LoadSrcE(LoadSrcE), .RdE(RdE), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E), .ValidM(ValidM), .RegWriteM(RegWriteM),
    .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM), .LoadSignM(LoadSignM),
    .LoadSrcM(LoadSrcM), .RdM(RdM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .PCPlus4M(PCPlus4M), .MisalignM(MisalignM), .FaultAddrM(FaultAddrM)
`ifdef EM_PERF_CNT_EN
    , .LoadCntM(LoadCntM), .StoreCntM(StoreCntM), .FaultCntM(FaultCntM), .BubbleCntM(BubbleCntM)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid, rw, mw, rs, ls, mis;
    logic [1:0]  lsrc;
    logic [4:0]  rd;
    logic [31:0] alu, wd, pc4, fa;
    bit          chk_data;
    logic [31:0] lc, sc, fc, bc;
  } exp_t;

  exp_t exp_q[$];
  exp_t st;
  int   compared = 0;
  int   mismatched = 0;
  int   slot = 0;

  function automatic exp_t reset_state();
    exp_t e;
    e = '{default: '0};
    e.chk_data = 1'b1;
    return e;
  endfunction

  // One instruction slot presented to EX; the model decides what MEM holds after the edge.
  task automatic step(input logic v, rw, mw, rs, ls, input logic [1:0] lsrc,
                      input logic [4:0] rd, input logic [31:0] alu, wd, pc,
                      input logic stall, flush);
    int unsigned bytes;
    bit is_mem, bad;
    @(negedge clk);
    rst_n = 1'b1;
    ValidE = v; RegWriteE = rw; MemWriteE = mw; ResultSrcE = rs; LoadSignE = ls;
    LoadSrcE = lsrc; RdE = rd; ALUResultE = alu; WriteDataE = wd; PCPlus4E = pc;
    StallM = stall; FlushM = flush;
    if (flush) begin
      st.valid = 0; st.rw = 0; st.mw = 0; st.rs = 0; st.mis = 0;
      st.chk_data = 0;
      st.bc = st.bc + 1;
    end else if (!stall) begin
      bytes  = (lsrc == 2'd0) ? 4 : (lsrc == 2'd1) ? 2 : 1;
      is_mem = v && (mw || rs);
      bad    = is_mem && (lsrc == 2'd3 || (alu % bytes) != 0);
      st.valid = v;
      st.rw  = v && rw && !bad;
      st.mw  = v && mw && !bad;
      st.rs  = v && rs && !bad;
      st.mis = bad;
      if (bad) st.fa = alu;
      st.ls = ls; st.lsrc = lsrc; st.rd = rd; st.alu = alu; st.wd = wd; st.pc4 = pc;
      st.chk_data = 1;
      if (!v) st.bc = st.bc + 1;
      else if (bad) st.fc = st.fc + 1;
      else begin
        if (rs) st.lc = st.lc + 1;
        if (mw) st.sc = st.sc + 1;
      end
    end
    exp_q.push_back(st);
  endtask

  always @(posedge clk) begin
    exp_t e;
    bit ok;
    #1;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      slot++;
      compared++;
      ok = (ValidM === e.valid) && (RegWriteM === e.rw) && (MemWriteM === e.mw) &&
           (ResultSrcM === e.rs) && (MisalignM === e.mis) && (FaultAddrM === e.fa);
      if (e.chk_data)
        ok = ok && (LoadSignM === e.ls) && (LoadSrcM === e.lsrc) && (RdM === e.rd) &&
             (ALUResultM === e.alu) && (WriteDataM === e.wd) && (PCPlus4M === e.pc4);
`ifdef EM_PERF_CNT_EN
      ok = ok && (LoadCntM === e.lc) && (StoreCntM === e.sc) &&
           (FaultCntM === e.fc) && (BubbleCntM === e.bc);
`endif
      if (!ok) begin
        mismatched++;
        $display("FAIL slot%0d: got v%b rw%b mw%b rs%b ls%b src%h rd%h mis%b alu%h wd%h pc%h fa%h; expected v%b rw%b mw%b rs%b ls%b src%h rd%h mis%b alu%h wd%h pc%h fa%h (data checked %0d)",
                 slot, ValidM, RegWriteM, MemWriteM, ResultSrcM, LoadSignM, LoadSrcM, RdM,
                 MisalignM, ALUResultM, WriteDataM, PCPlus4M, FaultAddrM,
                 e.valid, e.rw, e.mw, e.rs, e.ls, e.lsrc, e.rd, e.mis, e.alu, e.wd, e.pc4,
                 e.fa, e.chk_data);
`ifdef EM_PERF_CNT_EN
        $display("FAIL slot%0d counters: got %0d/%0d/%0d/%0d expected %0d/%0d/%0d/%0d", slot,
                 LoadCntM, StoreCntM, FaultCntM, BubbleCntM, e.lc, e.sc, e.fc, e.bc);
`endif
      end
    end
  end

  task automatic check_zero(input string name);
    logic [31:0] cnt_or;
    cnt_or = '0;
`ifdef EM_PERF_CNT_EN
    cnt_or = LoadCntM | StoreCntM | FaultCntM | BubbleCntM;
`endif
    compared++;
    if ({ValidM, RegWriteM, MemWriteM, ResultSrcM, LoadSignM, MisalignM, LoadSrcM, RdM} !== '0 ||
        ALUResultM !== '0 || WriteDataM !== '0 || PCPlus4M !== '0 || FaultAddrM !== '0 ||
        cnt_or !== '0) begin
      mismatched++;
      $display("FAIL %s: got v%b alu%h wd%h pc%h fa%h mis%b cnt%h, expected all zero",
               name, ValidM, ALUResultM, WriteDataM, PCPlus4M, FaultAddrM, MisalignM, cnt_or);
    end
  endtask

  initial begin
    logic [1:0]  lsrc;
    logic [31:0] addr;
    int unsigned op;
    st = reset_state();
    #1 check_zero("reset_state");

    // lw ok, sw misaligned, sh ok, lh misaligned, lb ok, illegal size load
    step(1, 1, 0, 1, 1, 2'd0, 5'd5, 32'h104, 32'h0, 32'h200, 0, 0);
    step(1, 0, 1, 0, 0, 2'd0, 5'd0, 32'h106, 32'hDEAD_BEEF, 32'h204, 0, 0);
    step(1, 0, 1, 0, 0, 2'd1, 5'd0, 32'h102, 32'h1234, 32'h208, 0, 0);
    step(1, 1, 0, 1, 1, 2'd1, 5'd7, 32'h103, 32'h0, 32'h20C, 0, 0);
    step(1, 1, 0, 1, 0, 2'd2, 5'd8, 32'h103, 32'h0, 32'h210, 0, 0);
    step(1, 1, 0, 1, 0, 2'd3, 5'd9, 32'h100, 32'h0, 32'h214, 0, 0);
    // three stalled cycles with changing inputs, then stall+flush
    for (int i = 0; i < 3; i++)
      step(1, 1, 1, 1, 1, 2'd0, 5'($urandom), $urandom, $urandom, $urandom, 1, 0);
    step(1, 1, 1, 0, 0, 2'd0, 5'd3, 32'h3, 32'h5, 32'h218, 1, 1);
    // ALU op with illegal size code and odd address never faults
    step(1, 1, 0, 0, 0, 2'd3, 5'd10, 32'h3, 32'h0, 32'h21C, 0, 0);

    // asynchronous reset between edges while MEM holds a valid slot
    step(1, 1, 0, 0, 0, 2'd0, 5'd11, 32'h55, 32'h0, 32'h220, 0, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_zero("async_reset");
    st = reset_state();

    for (int i = 0; i < 400; i++) begin
      op   = $urandom_range(0, 3);
      lsrc = 2'($urandom);
      addr = 32'h1000 + 32'($urandom_range(0, 63));
      step($urandom_range(0, 7) != 0, op != 1, op == 1, op == 0, 1'($urandom), lsrc,
           5'($urandom), addr, $urandom, $urandom,
           $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
    end

`ifdef EM_PERF_CNT_EN
    // counter wrap from all-ones
    @(posedge clk);
    #2 force dut.LoadCntM = '1;
    #1 release dut.LoadCntM;
    st.lc = '1;
    step(1, 1, 0, 1, 0, 2'd0, 5'd1, 32'h40, 32'h0, 32'h0, 0, 0);
`endif

    step(0, 0, 0, 0, 0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending slots, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
